// File: rtl/guess_game_ctrl.sv
//==============================================================================
// Module      : guess_game_ctrl
// Description : Number-guessing game sequencer (READY/GUESS/RESULT) with button
//               sync, LFSR target source and result-hold timeout.
//               Optional wrong-guess limit enabled by defining GUESS_LIMIT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module guess_game_ctrl #(
    parameter int         RESULT_HOLD = 50_000_000,
    parameter int         MAX_GUESSES = 5,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_guess,
    input  logic [3:0] sw_guess,
    output logic [1:0] state,
    output logic [3:0] target,
    output logic [3:0] last_guess,
    output logic       hi,
    output logic       lo,
    output logic       win,
    output logic       lose,
    output logic [3:0] guess_cnt
);

    localparam int                  c_HOLD_W    = (RESULT_HOLD > 2) ? $clog2(RESULT_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESULT_HOLD - 1);

    typedef enum logic [1:0] {
        S_READY  = 2'b00,
        S_GUESS  = 2'b01,
        S_RESULT = 2'b10
    } state_t;

    if (RESULT_HOLD < 2 || MAX_GUESSES < 1 || MAX_GUESSES > 15 || LFSR_SEED == 8'h00) begin : g_param_check
        $error("guess_game_ctrl: parameter out of range");
    end

    logic                r_start_meta, r_start_sync, r_start_prev;
    logic                r_guess_meta, r_guess_sync, r_guess_prev;
    logic [7:0]          r_lfsr;
    state_t              r_state;
    logic [3:0]          r_target, r_last_guess, r_guess_cnt;
    logic                r_hi, r_lo, r_win, r_lose;
    logic [c_HOLD_W-1:0] r_hold;

    logic                w_start_pulse, w_guess_pulse, w_lfsr_fb, w_limit_hit;
    logic [4:0]          w_cnt_inc;
    logic [3:0]          w_cnt_sat;
    state_t              w_state_nxt;
    logic [3:0]          w_target_nxt, w_last_nxt, w_cnt_nxt;
    logic                w_hi_nxt, w_lo_nxt, w_win_nxt, w_lose_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    assign w_start_pulse = r_start_sync & ~r_start_prev;
    assign w_guess_pulse = r_guess_sync & ~r_guess_prev;
    // Taps 8,6,5,4 give a maximal-length sequence that never visits zero
    assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cnt_inc     = {1'b0, r_guess_cnt} + 5'd1;
    assign w_cnt_sat     = (&r_guess_cnt) ? r_guess_cnt : w_cnt_inc[3:0];

`ifdef GUESS_LIMIT_EN
    assign w_limit_hit = (w_cnt_inc == 5'(MAX_GUESSES));
`else
    assign w_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_guess_meta <= 1'b0;
            r_guess_sync <= 1'b0;
            r_guess_prev <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_state      <= S_READY;
            r_target     <= '0;
            r_last_guess <= '0;
            r_guess_cnt  <= '0;
            r_hi         <= 1'b0;
            r_lo         <= 1'b0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_start_meta <= btn_start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_guess_meta <= btn_guess;
            r_guess_sync <= r_guess_meta;
            r_guess_prev <= r_guess_sync;
            r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
            r_state      <= w_state_nxt;
            r_target     <= w_target_nxt;
            r_last_guess <= w_last_nxt;
            r_guess_cnt  <= w_cnt_nxt;
            r_hi         <= w_hi_nxt;
            r_lo         <= w_lo_nxt;
            r_win        <= w_win_nxt;
            r_lose       <= w_lose_nxt;
            r_hold       <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_last_nxt   = r_last_guess;
        w_cnt_nxt    = r_guess_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_win_nxt    = r_win;
        w_lose_nxt   = r_lose;
        w_hold_nxt   = '0;
        case (r_state)
            S_READY: begin
                if (w_start_pulse) begin
                    w_state_nxt  = S_GUESS;
                    w_target_nxt = r_lfsr[3:0];
                    w_cnt_nxt    = '0;
                    {w_hi_nxt, w_lo_nxt, w_win_nxt, w_lose_nxt} = 4'b0000;
                end
            end
            S_GUESS: begin
                // Start has priority; a coincident guess is dropped
                if (w_start_pulse) begin
                    w_state_nxt = S_READY;
                    {w_hi_nxt, w_lo_nxt, w_win_nxt, w_lose_nxt} = 4'b0000;
                end else if (w_guess_pulse) begin
                    w_last_nxt = sw_guess;
                    w_cnt_nxt  = w_cnt_sat;
                    if (sw_guess == r_target) begin
                        w_state_nxt = S_RESULT;
                        w_win_nxt   = 1'b1;
                        w_hi_nxt    = 1'b0;
                        w_lo_nxt    = 1'b0;
                    end else if (w_limit_hit) begin
                        w_state_nxt = S_RESULT;
                        w_lose_nxt  = 1'b1;
                        w_hi_nxt    = 1'b0;
                        w_lo_nxt    = 1'b0;
                    end else begin
                        w_hi_nxt = (sw_guess > r_target);
                        w_lo_nxt = (sw_guess < r_target);
                    end
                end
            end
            S_RESULT: begin
                if (w_start_pulse || (r_hold == c_HOLD_LAST)) begin
                    w_state_nxt = S_READY;
                    {w_hi_nxt, w_lo_nxt, w_win_nxt, w_lose_nxt} = 4'b0000;
                end else begin
                    w_hold_nxt = r_hold + c_HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_READY;
                {w_hi_nxt, w_lo_nxt, w_win_nxt, w_lose_nxt} = 4'b0000;
            end
        endcase
    end

    assign state      = r_state;
    assign target     = r_target;
    assign last_guess = r_last_guess;
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign win        = r_win;
    assign lose       = r_lose;
    assign guess_cnt  = r_guess_cnt;

endmodule

`default_nettype wire

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Top-level sequencer for the number-guessing game.
- Generates the 2-bit game `state` that drives the seven-segment display mux: 00 = READY, 01 = GUESS, 10 = RESULT.
- Also produces the target number, the last guess, the HI/LO flags and the win/lose results that feed the flag and result decoders.
- Handles push-button synchronisation, edge detection, target generation (free-running LFSR) and the result-hold timeout.

Parameters:
- RESULT_HOLD, 50_000_000, cycles spent in RESULT before auto-return to READY (1 s at 50 MHz); minimum value 2.
- MAX_GUESSES, 5, wrong-guess limit; used only when the optional feature is enabled; range 1..15.
- LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_start  in  1  start/abort button, active-high level, asynchronous to clk.
- btn_guess  in  1  submit-guess button, active-high level, asynchronous to clk.
- sw_guess  in  4  guess value from switches, 0..15.
- state  out  2  game state to the display mux: 00 READY, 01 GUESS, 10 RESULT.
- target  out  4  secret number captured at game start.
- last_guess  out  4  most recently submitted guess.
- hi  out  1  last guess was greater than target.
- lo  out  1  last guess was less than target.
- win  out  1  game ended with a correct guess.
- lose  out  1  game ended because the guess limit was reached.
- guess_cnt  out  4  guesses submitted in the current game; saturates at 15.

Behaviour:
- Reset values: state=00, target=0, last_guess=0, hi=lo=win=lose=0, guess_cnt=0, LFSR=LFSR_SEED, hold counter=0, all synchroniser flops=0.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a previous-value flop.
  - pulse = sync2 & ~prev.
  - If an input rises before edge k, the pulse is high between edges k+1 and k+2, and the resulting state or register change is visible after edge k+2.
  - A held button produces exactly one pulse.
- LFSR:
  - 8-bit Fibonacci register, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle in all states and never reaches 0.
- READY:
  - start pulse: target <= LFSR[3:0]; guess_cnt <= 0; hi, lo, win, lose <= 0; go to GUESS.
  - guess pulse: ignored.
- GUESS:
  - start pulse: abort to READY; flags are cleared.
  - guess pulse:
    - last_guess <= sw_guess; guess_cnt <= guess_cnt+1, saturating at 15.
    - If sw_guess == target: win <= 1, hi = lo = 0, go to RESULT.
    - If sw_guess > target: hi <= 1, lo <= 0, stay in GUESS.
    - If sw_guess < target: lo <= 1, hi <= 0, stay in GUESS.
  - Simultaneous start and guess pulses: start wins and the guess is discarded.
- RESULT:
  - On entry the hold counter is 0; it increments every cycle.
  - When the counter reaches RESULT_HOLD-1: go to READY and clear the counter.
  - start pulse before timeout: go to READY immediately and clear the counter.
  - guess pulse: ignored.
  - On leaving RESULT: hi, lo, win, lose <= 0. target and last_guess are retained.
- State 11 is illegal; it goes to READY on the next edge with all flags cleared.
- win and lose are never high together. hi and lo are never high together.
- Asserting reset mid-game returns every output to its reset value immediately, without waiting for a clock edge.

Optional Feature:
- Macro: GUESS_LIMIT_EN.
- Defined:
  - In GUESS, a wrong guess that makes guess_cnt+1 == MAX_GUESSES sets lose <= 1, clears hi and lo, and goes to RESULT.
  - A correct guess on the final attempt sets win, not lose.
- Undefined:
  - Guesses are unlimited and lose is tied to 0.
  - guess_cnt still counts and saturates at 15.

Test Plan:
- Reset and start: assert reset, then pulse btn_start -> state=01, target equals the LFSR[3:0] at the capture edge, and the change lands exactly 3 edges after the button rise; all flags are 0.
- HI/LO: with target=T, guess sw=T+1 -> hi=1, lo=0, guess_cnt=1, state=01; then guess sw=T-1 -> hi=0, lo=1, guess_cnt=2.
- Win and timeout (RESULT_HOLD=8): guess sw=T -> win=1, state=10; exactly 8 cycles later state=00 and win=0, while last_guess=T is retained.
- Abort and priority: in GUESS, raise btn_start and btn_guess on the same cycle -> state=00, last_guess unchanged, guess_cnt unchanged; holding btn_guess for 100 cycles in GUESS produces exactly 1 increment.
- Guess limit (GUESS_LIMIT_EN, MAX_GUESSES=3): three wrong guesses -> lose=1, win=0, state=10 after the third; repeat with the third guess correct -> win=1, lose=0.
- Reset mid-RESULT: assert reset asynchronously between clock edges -> state=00 and all outputs at reset values before the next edge; the LFSR restarts at 8'hA5.
